// File: rtl/tx_pkg.sv
// Shared types and constants for the TX flow-control slice.
// Holds the controller state encoding, FIFO lane indices and default sizes.
package tx_pkg;

  localparam int TW_DEFAULT    = 5;
  localparam int DEPTH_DEFAULT = 16;
  localparam int NUM_FIFO      = 5;

  localparam int IDX_MAIN = 0;
  localparam int IDX_VC0  = 1;
  localparam int IDX_VC1  = 2;
  localparam int IDX_D0   = 3;
  localparam int IDX_D1   = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_flow_ctrl_if.sv
// Status/config bundle between the TX FIFOs and the flow controller.
// The master side is the TX datapath; the slave side is the controller.
interface tx_flow_ctrl_if
  import tx_pkg::*;
#(
  parameter int TW = TW_DEFAULT
);
  logic                     init;
  logic [NUM_FIFO*TW-1:0]   TH_LOW_IN;
  logic [NUM_FIFO*TW-1:0]   TH_HIGH_IN;
  logic [NUM_FIFO-1:0]      EMPTY_IN;
  logic [NUM_FIFO-1:0]      ERROR_IN;
  logic [NUM_FIFO*TW-1:0]   TH_LOW_OUT;
  logic [NUM_FIFO*TW-1:0]   TH_HIGH_OUT;
  logic [2:0]               STATE;
  logic                     IDLE_OUT;
  logic                     ACTIVE_OUT;
  logic                     ERROR_OUT;
  logic [NUM_FIFO-1:0]      ERR_SRC;
  logic                     CFG_VALID;

  modport master (
    output init, TH_LOW_IN, TH_HIGH_IN, EMPTY_IN, ERROR_IN,
    input  TH_LOW_OUT, TH_HIGH_OUT, STATE, IDLE_OUT, ACTIVE_OUT, ERROR_OUT,
           ERR_SRC, CFG_VALID
  );

  modport slave (
    input  init, TH_LOW_IN, TH_HIGH_IN, EMPTY_IN, ERROR_IN,
    output TH_LOW_OUT, TH_HIGH_OUT, STATE, IDLE_OUT, ACTIVE_OUT, ERROR_OUT,
           ERR_SRC, CFG_VALID
  );
endinterface

// File: rtl/tx_thresh_check.sv
// Combinational threshold sanity check: every FIFO needs 1 <= low < high <= DEPTH.
module tx_thresh_check
  import tx_pkg::*;
#(
  parameter int TW    = TW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic [NUM_FIFO*TW-1:0] th_low,
  input  logic [NUM_FIFO*TW-1:0] th_high,
  output logic                   valid
);
  localparam logic [TW:0] DEPTH_W = (TW+1)'(DEPTH);
  localparam logic [TW:0] ONE_W   = (TW+1)'(1);

  logic [TW:0] lo;
  logic [TW:0] hi;

  // One extra bit so a high threshold equal to DEPTH never aliases to zero.
  always_comb begin
    valid = 1'b1;
    lo    = '0;
    hi    = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      lo = {1'b0, th_low[i*TW +: TW]};
      hi = {1'b0, th_high[i*TW +: TW]};
      if (!((lo >= ONE_W) && (lo < hi) && (hi <= DEPTH_W)))
        valid = 1'b0;
    end
  end
endmodule

// File: rtl/tx_flow_ctrl.sv
// TX path flow controller: sequences RESET/INIT/IDLE/ACTIVE/ERROR, latches
// FIFO thresholds during INIT and reports idle/active/sticky-error status.
module tx_flow_ctrl
  import tx_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int TW        = TW_DEFAULT,
  parameter int IDLE_HOLD = 2
) (
  input logic           clk,
  input logic           RESET,
  tx_flow_ctrl_if.slave bus
);
  localparam logic [NUM_FIFO-1:0] ALL_EMPTY = '1;
  localparam logic [2:0]          HOLD_N    = 3'(IDLE_HOLD);

  tx_state_e              state;
  logic [2:0]             hold_cnt;
  logic [NUM_FIFO*TW-1:0] th_low;
  logic [NUM_FIFO*TW-1:0] th_high;
  logic [NUM_FIFO-1:0]    err_src;
  logic                   cfg_valid;
  logic                   cfg_ok;

  tx_thresh_check #(.TW(TW), .DEPTH(DEPTH)) u_thresh_check (
    .th_low  (bus.TH_LOW_IN),
    .th_high (bus.TH_HIGH_IN),
    .valid   (cfg_ok)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= ST_RESET;
      hold_cnt  <= '0;
      th_low    <= '0;
      th_high   <= '0;
      err_src   <= '0;
      cfg_valid <= 1'b0;
    end else begin
      case (state)
        ST_RESET: state <= ST_INIT;
        ST_INIT: begin
          th_low    <= bus.TH_LOW_IN;
          th_high   <= bus.TH_HIGH_IN;
          cfg_valid <= cfg_ok;
          if (!bus.init && cfg_ok) state <= ST_IDLE;
        end
        ST_IDLE: begin
          hold_cnt <= '0;
          if (|bus.ERROR_IN) begin
            state   <= ST_ERROR;
            err_src <= bus.ERROR_IN;
          end else if (bus.init) begin
            state <= ST_INIT;
          end else if (bus.EMPTY_IN != ALL_EMPTY) begin
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (|bus.ERROR_IN) begin
            state    <= ST_ERROR;
            err_src  <= bus.ERROR_IN;
            hold_cnt <= '0;
          end else if (bus.init) begin
            state    <= ST_INIT;
            hold_cnt <= '0;
          end else if (bus.EMPTY_IN == ALL_EMPTY) begin
            // hold_cnt counts all-empty cycles already seen; this one completes the run
            if (hold_cnt + 3'd1 >= HOLD_N) begin
              state    <= ST_IDLE;
              hold_cnt <= '0;
            end else if (hold_cnt != 3'd7) begin
              hold_cnt <= hold_cnt + 3'd1;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        ST_ERROR: err_src <= err_src | bus.ERROR_IN;
        default: begin
          state    <= ST_RESET;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.TH_LOW_OUT  = th_low;
  assign bus.TH_HIGH_OUT = th_high;
  assign bus.STATE       = state;
  assign bus.IDLE_OUT    = (state == ST_IDLE);
  assign bus.ACTIVE_OUT  = (state == ST_ACTIVE);
  assign bus.ERROR_OUT   = (state == ST_ERROR);
  assign bus.ERR_SRC     = err_src;
  assign bus.CFG_VALID   = cfg_valid;
endmodule

// File: tb/tb_tx_flow_ctrl.sv
// Self-checking bench for tx_flow_ctrl: directed scenarios then random traffic
// compared every cycle against a behavioural model of the controller.
module tb_tx_flow_ctrl;
  localparam int IDLE_HOLD = 2;
  localparam int DEPTH     = 16;

  logic clk = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_pass   = 0;

  tx_flow_ctrl_if bus ();

  tx_flow_ctrl #(.DEPTH(DEPTH), .TW(5), .IDLE_HOLD(IDLE_HOLD)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (spec-level: state number, latched config, error record)
  int          m_state;
  logic [24:0] m_lo, m_hi;
  logic        m_valid;
  logic [4:0]  m_err;
  int          m_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [24:0] pack5(input int d1, input int d0, input int vc1, input int vc0, input int mn);
    return {5'(d1), 5'(d0), 5'(vc1), 5'(vc0), 5'(mn)};
  endfunction

  function automatic logic ref_cfg_ok(input logic [24:0] lo, input logic [24:0] hi);
    for (int i = 0; i < 5; i++) begin
      int l, h;
      l = int'((lo >> (5 * i)) & 25'h1f);
      h = int'((hi >> (5 * i)) & 25'h1f);
      if (!(l >= 1 && l < h && h <= DEPTH)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lo = '0; m_hi = '0; m_valid = 1'b0; m_err = '0; m_run = 0;
  endtask

  task automatic model_edge();
    if (RESET) begin
      model_reset();
      return;
    end
    case (m_state)
      0: m_state = 1;
      1: begin
        m_lo    = bus.TH_LOW_IN;
        m_hi    = bus.TH_HIGH_IN;
        m_valid = ref_cfg_ok(bus.TH_LOW_IN, bus.TH_HIGH_IN);
        if (!bus.init && m_valid) m_state = 2;
      end
      2, 3: begin
        if (bus.ERROR_IN != 0) begin
          m_state = 4;
          m_err   = bus.ERROR_IN;
        end else if (bus.init) begin
          m_state = 1;
        end else if (bus.EMPTY_IN != 5'h1f) begin
          m_state = 3;
          m_run   = 0;
        end else if (m_state == 3) begin
          m_run++;
          if (m_run == IDLE_HOLD) begin
            m_state = 2;
            m_run   = 0;
          end
        end
      end
      default: m_err = m_err | bus.ERROR_IN;
    endcase
  endtask

  task automatic compare_all();
    check_eq("state",      32'(bus.STATE),      32'(m_state));
    check_eq("idle_out",   32'(bus.IDLE_OUT),   32'(m_state == 2));
    check_eq("active_out", 32'(bus.ACTIVE_OUT), 32'(m_state == 3));
    check_eq("error_out",  32'(bus.ERROR_OUT),  32'(m_state == 4));
    check_eq("err_src",    32'(bus.ERR_SRC),    32'(m_err));
    check_eq("cfg_valid",  32'(bus.CFG_VALID),  32'(m_valid));
    check_eq("th_low",     32'(bus.TH_LOW_OUT), 32'(m_lo));
    check_eq("th_high",    32'(bus.TH_HIGH_OUT), 32'(m_hi));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Called at posedge+1: assert reset between edges, check, release before next edge.
  task automatic async_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 RESET = 1'b0;
  endtask

  task automatic random_inputs();
    logic [24:0] lo, hi;
    for (int i = 0; i < 5; i++) begin
      int l, h;
      if ($urandom_range(0, 9) == 0) begin
        l = $urandom_range(0, 31);
        h = $urandom_range(0, 31);
      end else begin
        l = $urandom_range(1, 15);
        h = $urandom_range(l + 1, 16);
      end
      lo[5*i +: 5] = 5'(l);
      hi[5*i +: 5] = 5'(h);
    end
    bus.TH_LOW_IN  = lo;
    bus.TH_HIGH_IN = hi;
    bus.init       = ($urandom_range(0, 19) == 0);
    bus.EMPTY_IN   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'h1f;
    bus.ERROR_IN   = ($urandom_range(0, 99) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'h00;
    RESET          = ($urandom_range(0, 149) == 0);
  endtask

  logic [24:0] good_lo, good_hi;

  initial begin
    good_lo = pack5(1, 1, 3, 3, 1);
    good_hi = pack5(3, 3, 12, 12, 3);
    RESET = 1'b1;
    bus.init = 1'b0;
    bus.TH_LOW_IN = '0;
    bus.TH_HIGH_IN = '0;
    bus.EMPTY_IN = 5'h1f;
    bus.ERROR_IN = 5'h00;
    model_reset();

    // Reset, then configure
    cycle(); cycle();
    RESET = 1'b0; bus.init = 1'b1;
    bus.TH_LOW_IN = good_lo; bus.TH_HIGH_IN = good_hi;
    cycle(); cycle();
    check_eq("init_state", 32'(bus.STATE), 32'd1);
    check_eq("init_valid", 32'(bus.CFG_VALID), 32'd1);
    bus.init = 1'b0;
    cycle();
    check_eq("idle_after_init", 32'(bus.STATE), 32'd2);
    check_eq("th_low_latched", 32'(bus.TH_LOW_OUT), 32'(good_lo));

    // Bad config holds INIT until corrected
    bus.init = 1'b1; cycle();
    bus.init = 1'b0;
    bus.TH_LOW_IN = pack5(1, 1, 3, 12, 1); bus.TH_HIGH_IN = pack5(3, 3, 12, 3, 3);
    cycle(); cycle();
    check_eq("bad_cfg_valid", 32'(bus.CFG_VALID), 32'd0);
    check_eq("bad_cfg_state", 32'(bus.STATE), 32'd1);
    bus.TH_LOW_IN = good_lo; bus.TH_HIGH_IN = good_hi;
    cycle();

    // Activity and idle hold, including a blip that restarts the count
    bus.EMPTY_IN = 5'h1e; cycle();
    bus.EMPTY_IN = 5'h1f; cycle(); cycle();
    check_eq("hold_back_idle", 32'(bus.STATE), 32'd2);
    bus.EMPTY_IN = 5'h1e; cycle();
    bus.EMPTY_IN = 5'h1f; cycle();
    bus.EMPTY_IN = 5'h1e; cycle();
    bus.EMPTY_IN = 5'h1f; cycle();
    check_eq("blip_still_active", 32'(bus.STATE), 32'd3);
    cycle();

    // Error beats init; sticky ERR_SRC; init ignored in ERROR
    bus.EMPTY_IN = 5'h1e; cycle();
    bus.ERROR_IN = 5'b01000; bus.init = 1'b1; cycle();
    check_eq("err_entry_src", 32'(bus.ERR_SRC), 32'h08);
    bus.ERROR_IN = 5'h00; bus.init = 1'b0; cycle();
    bus.init = 1'b1; cycle();
    bus.ERROR_IN = 5'b00001; cycle();
    check_eq("err_sticky_src", 32'(bus.ERR_SRC), 32'h09);
    bus.ERROR_IN = 5'h00; bus.init = 1'b0; bus.EMPTY_IN = 5'h1f;
    RESET = 1'b1; cycle();
    RESET = 1'b0;

    // Re-init with new D1 thresholds
    bus.init = 1'b1; cycle(); cycle();
    bus.init = 1'b0; cycle();
    bus.init = 1'b1;
    bus.TH_LOW_IN = pack5(2, 1, 3, 3, 1); bus.TH_HIGH_IN = pack5(4, 3, 12, 12, 3);
    cycle(); cycle();
    check_eq("reinit_d1_high", 32'(bus.TH_HIGH_OUT[24:20]), 32'd4);
    bus.init = 1'b0; cycle();

    // Asynchronous reset in ACTIVE
    bus.EMPTY_IN = 5'h1e; cycle();
    async_reset();
    cycle();
    check_eq("post_async_init", 32'(bus.STATE), 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      if (!RESET && $urandom_range(0, 299) == 0) async_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
